// File: rtl/dma_arb_pkg.sv
// Shared types and default widths for the DMA arbiter.
package dma_arb_pkg;

  localparam int unsigned DEF_INW     = 512;
  localparam int unsigned DEF_ADDRW   = 32;
  localparam int unsigned DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_WAIT_WR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } dma_op_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the requester not served last wins.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last1,
  output logic [1:0] win_c
);

  // one-hot winner; a lone requester always wins
  always_comb begin
    win_c    = 2'b00;
    win_c[0] = req0 & (~req1 | last1);
    win_c[1] = req1 & (~req0 | ~last1);
  end

endmodule

// File: rtl/dma_arbiter.sv
// Arbitrates an instruction-fill reader and an audio writer onto one DMA port.
// Optional watchdog on the WAIT states: define DMA_ARB_TIMEOUT_EN.
module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned INW     = DEF_INW,
  parameter int unsigned ADDRW   = DEF_ADDRW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ic_req,
  input  logic [ADDRW-1:0] ic_addr,
  output logic             ic_gnt,
  output logic             ic_rd_valid,
  output logic [INW-1:0]   ic_data,
  input  logic             au_req,
  input  logic [ADDRW-1:0] au_addr,
  input  logic [INW-1:0]   au_data,
  output logic             au_gnt,
  output logic             au_done,
  input  logic             dma_ready,
  output logic [1:0]       dma_op,
  output logic [ADDRW-1:0] dma_addr,
  output logic [INW-1:0]   dma_wdata,
  input  logic             dma_rd_valid,
  input  logic [INW-1:0]   dma_rdata,
  input  logic             dma_tx_done,
  output logic             busy,
  output logic             timeout_err
);

  state_e           state_q, state_d;
  dma_op_e          op_q, op_d;
  logic             last_au_q, last_au_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [INW-1:0]   wdata_q, wdata_d;
  logic [INW-1:0]   ic_data_q, ic_data_d;
  logic             ic_gnt_q, ic_gnt_d, au_gnt_q, au_gnt_d;
  logic             ic_rd_valid_q, ic_rd_valid_d, au_done_q, au_done_d;
  logic             busy_q, timeout_err_q, timeout_err_d;
  logic [1:0]       win_c;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  rr_pick2 u_pick (
    .req0  (ic_req),
    .req1  (au_req),
    .last1 (last_au_q),
    .win_c (win_c)
  );

  // next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    last_au_d     = last_au_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    ic_data_d     = ic_data_q;
    ic_gnt_d      = 1'b0;
    au_gnt_d      = 1'b0;
    ic_rd_valid_d = 1'b0;
    au_done_d     = 1'b0;
    timeout_err_d = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_c[0]) begin
          ic_gnt_d  = 1'b1;
          addr_d    = ic_addr;
          wdata_d   = '0;
          op_d      = OP_READ;
          last_au_d = 1'b0;
          state_d   = ST_ISSUE;
        end else if (win_c[1]) begin
          au_gnt_d  = 1'b1;
          addr_d    = au_addr;
          wdata_d   = au_data;
          op_d      = OP_WRITE;
          last_au_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dma_ready) begin
          state_d = (op_q == OP_READ) ? ST_WAIT_RD : ST_WAIT_WR;
          op_d    = OP_IDLE;
`ifdef DMA_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT_RD: begin
        if (dma_rd_valid) begin
          ic_data_d     = dma_rdata;
          ic_rd_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
`endif
      end
      ST_WAIT_WR: begin
        if (dma_tx_done) begin
          au_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and registered outputs; reset aborts any transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_IDLE;
      last_au_q     <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      ic_data_q     <= '0;
      ic_gnt_q      <= 1'b0;
      au_gnt_q      <= 1'b0;
      ic_rd_valid_q <= 1'b0;
      au_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      last_au_q     <= last_au_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ic_data_q     <= ic_data_d;
      ic_gnt_q      <= ic_gnt_d;
      au_gnt_q      <= au_gnt_d;
      ic_rd_valid_q <= ic_rd_valid_d;
      au_done_q     <= au_done_d;
      busy_q        <= (state_d != ST_IDLE);
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef DMA_ARB_TIMEOUT_EN
  // watchdog counter for the WAIT states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign ic_gnt      = ic_gnt_q;
  assign au_gnt      = au_gnt_q;
  assign ic_rd_valid = ic_rd_valid_q;
  assign ic_data     = ic_data_q;
  assign au_done     = au_done_q;
  assign dma_op      = op_q;
  assign dma_addr    = addr_q;
  assign dma_wdata   = wdata_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Self-checking bench for dma_arbiter: randomized transactions against a
// transaction-level reference of the arbitration and handshake rules.
module tb_dma_arbiter;

  localparam int unsigned INW   = 512;
  localparam int unsigned ADDRW = 32;
  localparam int unsigned TO    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ic_req, au_req, dma_ready, dma_rd_valid, dma_tx_done;
  logic [ADDRW-1:0] ic_addr, au_addr;
  logic [INW-1:0]   au_data, dma_rdata;
  logic             ic_gnt, ic_rd_valid, au_gnt, au_done, busy, timeout_err;
  logic [INW-1:0]   ic_data, dma_wdata;
  logic [1:0]       dma_op;
  logic [ADDRW-1:0] dma_addr;

  int checks = 0;
  int errors = 0;

  // reference state: who was served last, and which requests are pending
  bit               last_au_m;
  bit               ic_pend, au_pend;

  dma_arbiter #(.INW(INW), .ADDRW(ADDRW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .ic_rd_valid(ic_rd_valid), .ic_data(ic_data),
    .au_req(au_req), .au_addr(au_addr), .au_data(au_data),
    .au_gnt(au_gnt), .au_done(au_done),
    .dma_ready(dma_ready), .dma_op(dma_op), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rd_valid(dma_rd_valid),
    .dma_rdata(dma_rdata), .dma_tx_done(dma_tx_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INW-1:0] rand_wide();
    logic [INW-1:0] r;
    for (int i = 0; i < int'(INW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ic_req = 0; au_req = 0; dma_ready = 0;
    dma_rd_valid = 0; dma_tx_done = 0; ic_addr = '0; au_addr = '0;
    au_data = '0; dma_rdata = '0;
    ic_pend = 0; au_pend = 0; last_au_m = 1;
    repeat (3) tick();
    checks++;
    if ({ic_gnt, au_gnt, ic_rd_valid, au_done, busy, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {ic_gnt, au_gnt, ic_rd_valid, au_done, busy, timeout_err});
    end
    checks++;
    if (dma_op !== 2'b00 || dma_addr !== '0 || dma_wdata !== '0 || ic_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: op=%b addr=%h required all zero", dma_op, dma_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Serve one transaction from the currently pending request set; DUT is IDLE.
  task automatic serve_one();
    bit               win_au;
    logic [1:0]       exp_op;
    logic [ADDRW-1:0] exp_addr;
    logic [INW-1:0]   exp_wd, rdat;
    int               rdly, wdly;
    win_au   = au_pend && (!ic_pend || !last_au_m);
    exp_op   = win_au ? 2'b10 : 2'b01;
    exp_addr = win_au ? au_addr : ic_addr;
    exp_wd   = win_au ? au_data : '0;
    rdly     = $urandom_range(0, 5);
    wdly     = $urandom_range(0, 4);
    rdat     = rand_wide();
    tick();
    checks++;
    if (ic_gnt !== !win_au || au_gnt !== win_au) begin
      errors++;
      $display("FAIL grant: ic_gnt=%b au_gnt=%b required ic=%b au=%b",
               ic_gnt, au_gnt, !win_au, win_au);
    end
    checks++;
    if (dma_op !== exp_op || dma_addr !== exp_addr || (win_au && dma_wdata !== exp_wd)) begin
      errors++;
      $display("FAIL issue_cmd: op=%b addr=%h required op=%b addr=%h",
               dma_op, dma_addr, exp_op, exp_addr);
    end
    last_au_m = win_au;
    if (win_au) begin au_req = 0; au_pend = 0; end
    else        begin ic_req = 0; ic_pend = 0; end
    // the other side may request while busy; it must wait for IDLE
    if ($urandom_range(0, 1) == 1) begin
      if (win_au && !ic_pend) begin ic_req = 1; ic_addr = $urandom; ic_pend = 1; end
      if (!win_au && !au_pend) begin
        au_req = 1; au_addr = $urandom; au_data = rand_wide(); au_pend = 1;
      end
    end
    repeat (rdly) begin
      tick();
      checks++;
      if (dma_op !== exp_op || dma_addr !== exp_addr || dma_wdata !== exp_wd ||
          ic_gnt !== 1'b0 || au_gnt !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL issue_hold: op=%b addr=%h gnt=%b%b busy=%b required op=%b addr=%h",
                 dma_op, dma_addr, ic_gnt, au_gnt, busy, exp_op, exp_addr);
      end
    end
    dma_ready = 1;
    tick();
    dma_ready = 0;
    checks++;
    if (dma_op !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: op=%b busy=%b required op=00 busy=1", dma_op, busy);
    end
    repeat (wdly) begin
      dma_rd_valid = win_au ? 1'($urandom_range(0, 1)) : 1'b0;
      dma_tx_done  = win_au ? 1'b0 : 1'($urandom_range(0, 1));
      dma_rdata    = rand_wide();
      tick();
      checks++;
      if (ic_rd_valid !== 1'b0 || au_done !== 1'b0 || busy !== 1'b1 ||
          ic_gnt !== 1'b0 || au_gnt !== 1'b0 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL wait_stray: rdv=%b done=%b busy=%b required 0 0 1",
                 ic_rd_valid, au_done, busy);
      end
    end
    dma_rd_valid = 0; dma_tx_done = 0;
    if (win_au) dma_tx_done = 1;
    else begin dma_rd_valid = 1; dma_rdata = rdat; end
    tick();
    dma_rd_valid = 0; dma_tx_done = 0;
    checks++;
    if (win_au ? (au_done !== 1'b1 || ic_rd_valid !== 1'b0)
               : (ic_rd_valid !== 1'b1 || ic_data !== rdat || au_done !== 1'b0)) begin
      errors++;
      $display("FAIL complete: rdv=%b done=%b data=%h required rdv=%b done=%b data=%h",
               ic_rd_valid, au_done, ic_data, !win_au, win_au, rdat);
    end
    checks++;
    if (busy !== 1'b0 || ic_gnt !== 1'b0 || au_gnt !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL back_idle: busy=%b gnt=%b%b terr=%b required all 0",
               busy, ic_gnt, au_gnt, timeout_err);
    end
  endtask

  task automatic test_random_traffic();
    // contention straight from reset: fill must win first
    ic_req = 1; ic_addr = 32'h100; ic_pend = 1;
    au_req = 1; au_addr = $urandom; au_data = rand_wide(); au_pend = 1;
    for (int n = 0; n < 40; n++) begin
      if (!ic_pend && $urandom_range(0, 1) == 1) begin
        ic_req = 1; ic_addr = $urandom; ic_pend = 1;
      end
      if (!au_pend && $urandom_range(0, 1) == 1) begin
        au_req = 1; au_addr = $urandom; au_data = rand_wide(); au_pend = 1;
      end
      if (!ic_pend && !au_pend) begin ic_req = 1; ic_addr = $urandom; ic_pend = 1; end
      serve_one();
    end
    // drain anything still pending
    while (ic_pend || au_pend) serve_one();
  endtask

  task automatic test_stray_idle();
    dma_tx_done = 1; dma_rd_valid = 1; dma_rdata = rand_wide();
    tick();
    dma_tx_done = 0; dma_rd_valid = 0;
    tick();
    checks++;
    if (ic_rd_valid !== 1'b0 || au_done !== 1'b0 || busy !== 1'b0 || dma_op !== 2'b00) begin
      errors++;
      $display("FAIL stray_idle: rdv=%b done=%b busy=%b op=%b required 0 0 0 00",
               ic_rd_valid, au_done, busy, dma_op);
    end
  endtask

  task automatic test_withdraw();
    logic [INW-1:0] rdat;
    rdat = rand_wide();
    ic_req = 1; ic_addr = $urandom;
    tick();
    ic_req = 0;
    au_req = 1; au_addr = $urandom; au_data = rand_wide();
    tick();
    au_req = 0;
    dma_ready = 1; tick(); dma_ready = 0;
    dma_rd_valid = 1; dma_rdata = rdat; tick(); dma_rd_valid = 0;
    last_au_m = 0;
    repeat (3) begin
      tick();
      checks++;
      if (au_gnt !== 1'b0 || ic_gnt !== 1'b0 || dma_op !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL withdraw: au_gnt=%b op=%b busy=%b required 0 00 0",
                 au_gnt, dma_op, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    ic_req = 1; ic_addr = $urandom;
    tick();
    ic_req = 0;
    dma_ready = 1; tick(); dma_ready = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || dma_op !== 2'b00 || dma_addr !== '0 || ic_data !== '0 ||
        ic_gnt !== 1'b0 || ic_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b op=%b addr=%h required all 0", busy, dma_op, dma_addr);
    end
    rst_n = 1;
    last_au_m = 1;
    dma_rd_valid = 1; dma_rdata = rand_wide();
    tick();
    dma_rd_valid = 0;
    repeat (2) begin
      tick();
      checks++;
      if (ic_rd_valid !== 1'b0 || busy !== 1'b0 || ic_data !== '0) begin
        errors++;
        $display("FAIL reset_abort: rdv=%b busy=%b required 0 0", ic_rd_valid, busy);
      end
    end
  endtask

  task automatic test_watchdog();
    au_req = 1; au_addr = $urandom; au_data = rand_wide();
    tick();
    au_req = 0; last_au_m = 1;
    dma_ready = 1; tick(); dma_ready = 0;
`ifdef DMA_ARB_TIMEOUT_EN
    repeat (TO - 1) begin
      tick();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL early_timeout: terr=%b busy=%b required 0 1", timeout_err, busy);
      end
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || au_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout: terr=%b busy=%b done=%b required 1 0 0",
               timeout_err, busy, au_done);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: terr=%b required 0", timeout_err);
    end
`else
    repeat (3 * TO) tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: terr=%b busy=%b required 0 1", timeout_err, busy);
    end
    dma_tx_done = 1; tick(); dma_tx_done = 0;
    checks++;
    if (au_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_done: done=%b busy=%b required 1 0", au_done, busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_random_traffic();
    test_stray_idle();
    test_withdraw();
    test_reset_mid();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter INW, 512, width of the common data bus (bits).
REQ-002 Parameter ADDRW, 32, memory address width.
REQ-003 Parameter TIMEOUT, 1024, watchdog limit in cycles (used only under DMA_ARB_TIMEOUT_EN).
REQ-004 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 ic_req input 1, instruction-fill read request; ic_addr input ADDRW, fill address; ic_gnt output 1, grant pulse.
REQ-006 ic_rd_valid output 1, fill-data-valid pulse; ic_data output INW, registered fill data.
REQ-007 au_req input 1, audio writeback request; au_addr input ADDRW, write address; au_data input INW, write data.
REQ-008 au_gnt output 1, grant pulse; au_done output 1, write-complete pulse.
REQ-009 dma_ready input 1, DMA accepts command; dma_op output 2 (00 idle, 01 read, 10 write); dma_addr output ADDRW; dma_wdata output INW.
REQ-010 dma_rd_valid input 1, read data valid; dma_rdata input INW; dma_tx_done input 1, write complete.
REQ-011 busy output 1, high in any state other than IDLE; timeout_err output 1, watchdog pulse.

Function
REQ-012 The FSM SHALL have the states IDLE, ISSUE, WAIT_RD and WAIT_WR.
REQ-013 IDLE: if any req is sampled high, the arbiter SHALL pulse the winner's gnt for exactly one cycle, latch its addr (and au_data), and enter ISSUE on the next edge.
REQ-014 Arbitration SHALL be round-robin: when both reqs are high, grant the requester not served last; a lone requester always wins.
REQ-015 A req dropped before its gnt SHALL be treated as withdrawn, with no gnt and no DMA command issued.
REQ-016 ISSUE: dma_op, dma_addr and dma_wdata SHALL be held stable until dma_ready is sampled high; the FSM SHALL then enter WAIT_RD (read) or WAIT_WR (write), and dma_op SHALL return to 00 the cycle after acceptance.
REQ-017 WAIT_RD: on dma_rd_valid, ic_data SHALL register dma_rdata and ic_rd_valid SHALL pulse the following cycle; the FSM SHALL return to IDLE.
REQ-018 WAIT_WR: on dma_tx_done, au_done SHALL pulse the following cycle and the FSM SHALL return to IDLE.
REQ-019 Minimum req-to-gnt latency SHALL be 1 cycle; back-to-back transactions SHALL re-arbitrate in the first IDLE cycle, with no dead cycle added.
REQ-020 dma_rd_valid or dma_tx_done arriving in any state other than its matching WAIT state SHALL be ignored.
REQ-021 A new req arriving while busy SHALL wait in IDLE arbitration; requests SHALL NOT be queued beyond one per requester.

Reset
REQ-022 rst_n low SHALL force IDLE and drive every output to 0, including ic_data.
REQ-023 After reset, the round-robin pointer SHALL mark audio as last served, so the instruction-fill requester wins the first contention.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction silently, with no done or rd_valid pulse.

Configuration
REQ-025 With DMA_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_RD and WAIT_WR; when it reaches TIMEOUT, timeout_err SHALL pulse for one cycle and the FSM SHALL return to IDLE without a completion pulse.
REQ-026 Without DMA_ARB_TIMEOUT_EN, the counter SHALL be absent, timeout_err SHALL be tied to 0, and the WAIT states SHALL wait indefinitely.

Structure
REQ-027 The package dma_arb_pkg SHALL hold the FSM state enum, the dma_op encoding enum and the default width constants.
REQ-028 Two-way round-robin selection SHALL live in the sub-module rr_pick2 (inputs: two reqs and the last-served flag; output: one-hot winner).

Verification
REQ-029 ic_req=1, ic_addr=0x100, dma_ready=1, dma_rd_valid with dma_rdata=pattern A two cycles later -> ic_gnt pulse at +1 cycle, dma_op=01 with dma_addr=0x100, ic_rd_valid=1 and ic_data=A one cycle after rd_valid.
REQ-030 Both reqs high from reset -> instruction fill granted first, audio granted second (dma_op=10, au_addr driven), then instruction fill granted again if still requesting.
REQ-031 au_req with dma_ready held low for 5 cycles -> dma_op=10 and dma_wdata stable for all 5 cycles, WAIT_WR entered on the cycle ready is sampled high, au_done one cycle after dma_tx_done.
REQ-032 Stray dma_tx_done while in IDLE, and dma_rd_valid during WAIT_WR -> no output pulses and no state change.
REQ-033 rst_n pulsed low during WAIT_RD -> all outputs 0 immediately, no ic_rd_valid afterwards; TIMEOUT=8 build with DMA_ARB_TIMEOUT_EN and no completion -> timeout_err pulse after 8 WAIT cycles, then busy=0.
